// File: rtl/interrupt_sequencer_if.sv
// Bundles the sequencer's interrupt inputs and the decoded control and vector outputs.
// Clock and reset are kept as plain ports on the sequencer itself.
interface interrupt_sequencer_if;
    logic       NMI_n;
    logic       IRQ_n;
    logic       iFlag;
    logic       sync;
    logic       brkOp;
    logic       forceBrk;
    logic       intActive;
    logic [2:0] seqCycle;
    logic       suppressWrite;
    logic       bFlag;
    logic       setI;
    logic       O_ADL0;
    logic       O_ADL1;
    logic       O_ADL2;
    logic       vecHi;
    logic       intDone;

    modport master (
        output NMI_n, IRQ_n, iFlag, sync, brkOp,
        input  forceBrk, intActive, seqCycle, suppressWrite, bFlag, setI,
        input  O_ADL0, O_ADL1, O_ADL2, vecHi, intDone
    );

    modport slave (
        input  NMI_n, IRQ_n, iFlag, sync, brkOp,
        output forceBrk, intActive, seqCycle, suppressWrite, bFlag, setI,
        output O_ADL0, O_ADL1, O_ADL2, vecHi, intDone
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// 6502C interrupt/reset sequencer: latches NMI edges, arbitrates RES/NMI/IRQ/BRK at
// instruction boundaries and runs the 7-cycle sequence that drives the vector lines.
module interrupt_sequencer (
    input  logic                    phi2,
    input  logic                    rst,
    interrupt_sequencer_if.slave    bus
);

    typedef enum logic { ST_IDLE, ST_SEQ } state_t;
    typedef enum logic [1:0] { SRC_RES, SRC_NMI, SRC_IRQ, SRC_BRK } src_t;

    state_t     state, state_n;
    src_t       src, src_n;
    logic [2:0] cyc, cyc_n;
    logic       is_brk, is_brk_n;
    logic       res_pend, res_pend_n;
    logic       nmi_latch, nmi_latch_n;
    logic       nmi_prev;

    logic       force_brk_d, int_active_d, suppress_write_d, b_flag_d;
    logic       set_i_d, adl0_d, adl1_d, adl2_d, vec_hi_d, int_done_d;
    logic [2:0] seq_cycle_d;

    always_comb begin
        state_n    = state;
        src_n      = src;
        cyc_n      = cyc;
        is_brk_n   = is_brk;
        res_pend_n = res_pend;

        // A new falling edge on the clearing edge must not be lost, so set wins.
        nmi_latch_n = (nmi_prev & ~bus.NMI_n) |
                      (nmi_latch & ~((state == ST_SEQ) && (cyc == 3'd4) && (src == SRC_NMI)));

        if (state == ST_IDLE) begin
            if (bus.sync) begin
                if (res_pend || nmi_latch || (!bus.IRQ_n && !bus.iFlag) || bus.brkOp) begin
                    state_n    = ST_SEQ;
                    cyc_n      = 3'd0;
                    res_pend_n = 1'b0;
                    if (res_pend)                     src_n = SRC_RES;
                    else if (nmi_latch)               src_n = SRC_NMI;
                    else if (!bus.IRQ_n && !bus.iFlag) src_n = SRC_IRQ;
                    else                              src_n = SRC_BRK;
                    is_brk_n = (src_n == SRC_BRK);
                end
            end
        end else begin
            if (cyc == 3'd6) begin
                state_n = ST_IDLE;
                cyc_n   = 3'd0;
            end else begin
                cyc_n = cyc + 3'd1;
            end
            // NMI may still take over the vector until the low-byte address is committed.
            if ((cyc <= 3'd3) && nmi_latch && ((src == SRC_IRQ) || (src == SRC_BRK)))
                src_n = SRC_NMI;
        end
    end

    // Outputs are decoded from next-state values so they register alongside the state.
    always_comb begin
        force_brk_d      = 1'b0;
        int_active_d     = 1'b0;
        seq_cycle_d      = 3'd0;
        suppress_write_d = 1'b0;
        b_flag_d         = 1'b0;
        set_i_d          = 1'b0;
        adl0_d           = 1'b1;
        adl1_d           = 1'b1;
        adl2_d           = 1'b1;
        vec_hi_d         = 1'b0;
        int_done_d       = 1'b0;

        if (state_n == ST_SEQ) begin
            int_active_d     = 1'b1;
            seq_cycle_d      = cyc_n;
            force_brk_d      = (cyc_n == 3'd0) && !is_brk_n;
            b_flag_d         = is_brk_n;
            suppress_write_d = (src_n == SRC_RES) && (cyc_n >= 3'd2) && (cyc_n <= 3'd4);
            if (cyc_n == 3'd5) begin
                set_i_d = 1'b1;
                adl0_d  = 1'b0;
                adl1_d  = (src_n != SRC_RES);
                adl2_d  = (src_n != SRC_NMI);
            end
            if (cyc_n == 3'd6) begin
                vec_hi_d   = 1'b1;
                int_done_d = 1'b1;
                adl1_d     = (src_n != SRC_RES);
                adl2_d     = (src_n != SRC_NMI);
            end
        end
    end

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            src               <= SRC_RES;
            cyc               <= 3'd0;
            is_brk            <= 1'b0;
            res_pend          <= 1'b1;
            nmi_latch         <= 1'b0;
            nmi_prev          <= 1'b1;
            bus.forceBrk      <= 1'b0;
            bus.intActive     <= 1'b0;
            bus.seqCycle      <= 3'd0;
            bus.suppressWrite <= 1'b0;
            bus.bFlag         <= 1'b0;
            bus.setI          <= 1'b0;
            bus.O_ADL0        <= 1'b1;
            bus.O_ADL1        <= 1'b1;
            bus.O_ADL2        <= 1'b1;
            bus.vecHi         <= 1'b0;
            bus.intDone       <= 1'b0;
        end else begin
            state             <= state_n;
            src               <= src_n;
            cyc               <= cyc_n;
            is_brk            <= is_brk_n;
            res_pend          <= res_pend_n;
            nmi_latch         <= nmi_latch_n;
            nmi_prev          <= bus.NMI_n;
            bus.forceBrk      <= force_brk_d;
            bus.intActive     <= int_active_d;
            bus.seqCycle      <= seq_cycle_d;
            bus.suppressWrite <= suppress_write_d;
            bus.bFlag         <= b_flag_d;
            bus.setI          <= set_i_d;
            bus.O_ADL0        <= adl0_d;
            bus.O_ADL1        <= adl1_d;
            bus.O_ADL2        <= adl2_d;
            bus.vecHi         <= vec_hi_d;
            bus.intDone       <= int_done_d;
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: each sequence is checked cycle by cycle
// against hand-written output rows.
module tb_interrupt_sequencer;

    typedef logic [12:0] row_t;
    typedef row_t seq_t [7];

    logic phi2;
    logic rst;
    int   n_tests;
    int   n_fail;

    interrupt_sequencer_if ifc ();

    interrupt_sequencer dut (
        .phi2 (phi2),
        .rst  (rst),
        .bus  (ifc.slave)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    // Row layout: forceBrk, intActive, seqCycle[2:0], suppressWrite, bFlag, setI,
    // O_ADL0, O_ADL1, O_ADL2, vecHi, intDone
    function automatic row_t pk(input bit fb, input bit act, input bit [2:0] cy,
                                input bit sw, input bit bf, input bit si,
                                input bit a0, input bit a1, input bit a2,
                                input bit vh, input bit dn);
        return {fb, act, cy, sw, bf, si, a0, a1, a2, vh, dn};
    endfunction

    function automatic row_t outs();
        return {ifc.forceBrk, ifc.intActive, ifc.seqCycle, ifc.suppressWrite, ifc.bFlag,
                ifc.setI, ifc.O_ADL0, ifc.O_ADL1, ifc.O_ADL2, ifc.vecHi, ifc.intDone};
    endfunction

    task automatic check_eq(input string tag, input row_t got, input row_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge phi2);
        #1;
    endtask

    row_t idle_row;
    seq_t res_rows, irq_rows, brk_rows, brk_hij_rows, nmi_rows;

    // First edge is the arbitration edge; the last edge checked is the exit to IDLE.
    task automatic run_seq(input string tag, input seq_t rows, input int nmi_cyc);
        step();
        ifc.sync  = 1'b0;
        ifc.brkOp = 1'b0;
        for (int c = 0; c < 7; c++) begin
            check_eq($sformatf("%s c%0d", tag, c), outs(), rows[c]);
            if (c == nmi_cyc) ifc.NMI_n = 1'b0;
            step();
        end
        check_eq({tag, " exit"}, outs(), idle_row);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_row = pk(0,0,0,0,0,0,1,1,1,0,0);
        res_rows = '{pk(1,1,0,0,0,0,1,1,1,0,0), pk(0,1,1,0,0,0,1,1,1,0,0),
                     pk(0,1,2,1,0,0,1,1,1,0,0), pk(0,1,3,1,0,0,1,1,1,0,0),
                     pk(0,1,4,1,0,0,1,1,1,0,0), pk(0,1,5,0,0,1,0,0,1,0,0),
                     pk(0,1,6,0,0,0,1,0,1,1,1)};
        irq_rows = '{pk(1,1,0,0,0,0,1,1,1,0,0), pk(0,1,1,0,0,0,1,1,1,0,0),
                     pk(0,1,2,0,0,0,1,1,1,0,0), pk(0,1,3,0,0,0,1,1,1,0,0),
                     pk(0,1,4,0,0,0,1,1,1,0,0), pk(0,1,5,0,0,1,0,1,1,0,0),
                     pk(0,1,6,0,0,0,1,1,1,1,1)};
        brk_rows = '{pk(0,1,0,0,1,0,1,1,1,0,0), pk(0,1,1,0,1,0,1,1,1,0,0),
                     pk(0,1,2,0,1,0,1,1,1,0,0), pk(0,1,3,0,1,0,1,1,1,0,0),
                     pk(0,1,4,0,1,0,1,1,1,0,0), pk(0,1,5,0,1,1,0,1,1,0,0),
                     pk(0,1,6,0,1,0,1,1,1,1,1)};
        brk_hij_rows = '{pk(0,1,0,0,1,0,1,1,1,0,0), pk(0,1,1,0,1,0,1,1,1,0,0),
                         pk(0,1,2,0,1,0,1,1,1,0,0), pk(0,1,3,0,1,0,1,1,1,0,0),
                         pk(0,1,4,0,1,0,1,1,1,0,0), pk(0,1,5,0,1,1,0,1,0,0,0),
                         pk(0,1,6,0,1,0,1,1,0,1,1)};
        nmi_rows = '{pk(1,1,0,0,0,0,1,1,1,0,0), pk(0,1,1,0,0,0,1,1,1,0,0),
                     pk(0,1,2,0,0,0,1,1,1,0,0), pk(0,1,3,0,0,0,1,1,1,0,0),
                     pk(0,1,4,0,0,0,1,1,1,0,0), pk(0,1,5,0,0,1,0,1,0,0,0),
                     pk(0,1,6,0,0,0,1,1,0,1,1)};

        rst       = 1'b1;
        ifc.NMI_n = 1'b1;
        ifc.IRQ_n = 1'b1;
        ifc.iFlag = 1'b1;
        ifc.sync  = 1'b0;
        ifc.brkOp = 1'b0;
        step();
        check_eq("reset hold 1", outs(), idle_row);
        step();
        check_eq("reset hold 2", outs(), idle_row);
        rst = 1'b0;
        step();
        check_eq("idle no sync", outs(), idle_row);

        // Reset sequence wins even with an unmasked IRQ pending.
        ifc.IRQ_n = 1'b0;
        ifc.iFlag = 1'b0;
        ifc.sync  = 1'b1;
        run_seq("res", res_rows, -1);

        ifc.sync = 1'b1;
        run_seq("irq", irq_rows, -1);

        ifc.iFlag = 1'b1;
        ifc.sync  = 1'b1;
        step();
        check_eq("irq masked 1", outs(), idle_row);
        step();
        check_eq("irq masked 2", outs(), idle_row);
        ifc.brkOp = 1'b1;
        run_seq("brk", brk_rows, -1);

        // NMI falling in cyc 2 hijacks the BRK vector.
        ifc.brkOp = 1'b1;
        ifc.sync  = 1'b1;
        run_seq("brk hijack", brk_hij_rows, 2);
        ifc.NMI_n = 1'b1;
        ifc.sync  = 1'b1;
        step();
        check_eq("nmi latch cleared", outs(), idle_row);

        // NMI falling in cyc 5 is too late; taken at the next boundary.
        ifc.brkOp = 1'b1;
        ifc.sync  = 1'b1;
        run_seq("brk late nmi", brk_rows, 5);
        ifc.NMI_n = 1'b1;
        ifc.sync  = 1'b1;
        run_seq("nmi deferred", nmi_rows, -1);

        // NMI and IRQ both pending at a boundary.
        ifc.sync  = 1'b0;
        ifc.NMI_n = 1'b0;
        step();
        check_eq("nmi latched idle", outs(), idle_row);
        ifc.NMI_n = 1'b1;
        ifc.IRQ_n = 1'b0;
        ifc.iFlag = 1'b0;
        ifc.sync  = 1'b1;
        run_seq("nmi over irq", nmi_rows, -1);
        ifc.iFlag = 1'b1;
        ifc.sync  = 1'b1;
        step();
        check_eq("irq after setI", outs(), idle_row);

        // Asynchronous reset in cyc 3 of an IRQ sequence.
        ifc.iFlag = 1'b0;
        ifc.IRQ_n = 1'b0;
        ifc.sync  = 1'b1;
        step();
        ifc.sync = 1'b0;
        check_eq("rst irq c0", outs(), irq_rows[0]);
        step();
        step();
        step();
        check_eq("rst irq c3", outs(), irq_rows[3]);
        #2 rst = 1'b1;
        #1 check_eq("async rst", outs(), idle_row);
        #2 rst = 1'b0;
        ifc.sync = 1'b1;
        run_seq("res after rst", res_rows, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
